inst_router_rr: RTL and testbench

// Registered, parametrised successor to the decode-stage instruction router. Accepts one

---
 rtl/inst_router_rr_if.sv | 58 +++++
 rtl/inst_router_rr.sv | 123 ++++++++++++
 tb/tb_inst_router_rr.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_router_rr_if.sv
// Shared op encoding plus the decode-to-execute bundle of the registered instruction router.
// rv_op_vec is a bitmask indexed by rv_uop: bit n set means the pipe accepts op n.
package inst_router_rr_pkg;

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_ADDI    = 4'd1,
    OP_MUL     = 4'd2,
    OP_LW      = 4'd3,
    OP_SW      = 4'd4,
    OP_JAL     = 4'd5,
    OP_JR      = 4'd6,
    OP_BNE     = 4'd7,
    OP_CSRR    = 4'd8,
    OP_CSRW    = 4'd9,
    OP_ILLEGAL = 4'd10
  } rv_uop;

  localparam int RV_NUM_OPS = 16;

  typedef logic [RV_NUM_OPS-1:0] rv_op_vec;

  localparam rv_op_vec p_tinyrv1 = rv_op_vec'(16'h03FF);

  function automatic logic op_enabled(input rv_op_vec subset, input rv_uop op);
    return subset[op];
  endfunction

endpackage

interface inst_router_rr_if
  import inst_router_rr_pkg::*;
#(
  parameter int p_num_pipes = 3,
  parameter int p_data_bits = 32
) ();

  rv_uop                   uop;
  logic [p_data_bits-1:0]  data;
  logic                    val;
  logic                    rdy;
  logic                    unsup;
  logic [p_num_pipes-1:0]  ex_val;
  logic [p_num_pipes-1:0]  ex_rdy;
  rv_uop                   ex_uop  [p_num_pipes];
  logic [p_data_bits-1:0]  ex_data [p_num_pipes];

  modport master (
    output uop, data, val, ex_rdy,
    input  rdy, unsup, ex_val, ex_uop, ex_data
  );

  modport slave (
    input  uop, data, val, ex_rdy,
    output rdy, unsup, ex_val, ex_uop, ex_data
  );

endinterface

// File: rtl/inst_router_rr.sv
// Registered instruction router: steers one decoded uop per cycle into a one-entry output
// register of a capable execute pipe, round-robin among eligible pipes; unsupported uops are dropped.
module inst_router_rr
  import inst_router_rr_pkg::*;
#(
  parameter int                          p_num_pipes    = 3,
  parameter rv_op_vec [p_num_pipes-1:0]  p_pipe_subsets = {p_num_pipes{p_tinyrv1}},
  parameter int                          p_data_bits    = 32,
  parameter bit                          p_rr_enable    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  inst_router_rr_if.slave  bus
);

  localparam int LP_PTR_BITS = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;
  localparam logic [LP_PTR_BITS-1:0] LP_LAST = LP_PTR_BITS'(p_num_pipes - 1);

  logic [p_num_pipes-1:0]  r_ex_val;
  rv_uop                   r_ex_uop  [p_num_pipes];
  logic [p_data_bits-1:0]  r_ex_data [p_num_pipes];
  logic [LP_PTR_BITS-1:0]  r_rr_ptr;
  logic                    r_unsup;

  logic [p_num_pipes-1:0]  w_capable;
  logic [p_num_pipes-1:0]  w_free;
  logic [p_num_pipes-1:0]  w_elig;
  logic [p_num_pipes-1:0]  w_load;
  logic                    w_any_capable;
  logic                    w_any_elig;
  logic                    w_accept;
  logic                    w_drop;
  logic [LP_PTR_BITS-1:0]  w_start;
  logic [LP_PTR_BITS-1:0]  w_winner;

  // A slot is free when empty or when its current occupant leaves this cycle.
  always_comb begin
    w_capable = '0;
    w_free    = '0;
    for (int i = 0; i < p_num_pipes; i++) begin
      w_capable[i] = op_enabled(p_pipe_subsets[i], bus.uop);
      w_free[i]    = ~r_ex_val[i] | bus.ex_rdy[i];
    end
  end

  assign w_elig        = w_capable & w_free;
  assign w_any_capable = |w_capable;
  assign w_any_elig    = |w_elig;
  assign w_accept      = bus.val & w_any_elig;
  assign w_drop        = bus.val & ~w_any_capable;
  assign w_start       = p_rr_enable ? r_rr_ptr : '0;

  assign bus.rdy = w_any_elig | ~w_any_capable;

  // Circular first-set search over elig, beginning at the round-robin pointer.
  always_comb begin : winnerSearch
    int   idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    w_winner = '0;
    for (int k = 0; k < p_num_pipes; k++) begin
      idx = int'(w_start) + k;
      if (idx >= p_num_pipes) begin
        idx = idx - p_num_pipes;
      end
      if (!found && w_elig[idx]) begin
        found    = 1'b1;
        w_winner = LP_PTR_BITS'(idx);
      end
    end
  end

  always_comb begin
    w_load = '0;
    for (int i = 0; i < p_num_pipes; i++) begin
      w_load[i] = w_accept && (w_winner == LP_PTR_BITS'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_val <= '0;
      r_rr_ptr <= '0;
      r_unsup  <= 1'b0;
    end else begin
      r_unsup <= w_drop;
      if (w_accept) begin
        r_rr_ptr <= (w_winner == LP_LAST) ? '0 : w_winner + 1'b1;
      end
      for (int i = 0; i < p_num_pipes; i++) begin
        if (w_load[i]) begin
          r_ex_val[i] <= 1'b1;
        end else if (bus.ex_rdy[i]) begin
          r_ex_val[i] <= 1'b0;
        end
      end
    end
  end

  // Payload registers only move on a load, so a stalled slot holds its uop/data steady.
  always_ff @(posedge clk) begin
    for (int i = 0; i < p_num_pipes; i++) begin
      if (w_load[i]) begin
        r_ex_uop[i]  <= bus.uop;
        r_ex_data[i] <= bus.data;
      end
    end
  end

  assign bus.ex_val  = r_ex_val;
  assign bus.unsup   = r_unsup;
  assign bus.ex_uop  = r_ex_uop;
  assign bus.ex_data = r_ex_data;

  singleLoad: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_load));

  for (genvar g = 0; g < p_num_pipes; g++) begin : gHoldCheck
    heldStable: assert property (@(posedge clk) disable iff (!rst_n)
      (r_ex_val[g] && !bus.ex_rdy[g]) |=> $stable(r_ex_data[g]));
  end

endmodule

// File: tb/tb_inst_router_rr.sv
// Bench for inst_router_rr: three router instances (round-robin, fixed priority, mixed subsets)
// share one uop stream and are compared each cycle against a behavioural reference model.
module tb_inst_router_rr;
  import inst_router_rr_pkg::*;

  localparam int NP = 3;
  localparam int DB = 32;
  localparam int ND = 3;

  localparam rv_op_vec SW_BIT  = rv_op_vec'(16'h0001) << int'(OP_SW);
  localparam rv_op_vec MUL_BIT = rv_op_vec'(16'h0001) << int'(OP_MUL);
  localparam rv_op_vec SUB_ALU = p_tinyrv1 & ~SW_BIT & ~MUL_BIT;
  localparam rv_op_vec [NP-1:0] SUBS_C = {SUB_ALU, MUL_BIT, SUB_ALU};

  logic            clk;
  logic            rst_n;
  rv_uop           drvUop;
  logic [DB-1:0]   drvData;
  logic            drvVal;
  logic [NP-1:0]   drvExRdy [ND];

  int compareCount;
  int mismatchCount;

  inst_router_rr_if #(.p_num_pipes(NP), .p_data_bits(DB)) ifA ();
  inst_router_rr_if #(.p_num_pipes(NP), .p_data_bits(DB)) ifB ();
  inst_router_rr_if #(.p_num_pipes(NP), .p_data_bits(DB)) ifC ();

  assign ifA.uop = drvUop;  assign ifA.data = drvData;  assign ifA.val = drvVal;  assign ifA.ex_rdy = drvExRdy[0];
  assign ifB.uop = drvUop;  assign ifB.data = drvData;  assign ifB.val = drvVal;  assign ifB.ex_rdy = drvExRdy[1];
  assign ifC.uop = drvUop;  assign ifC.data = drvData;  assign ifC.val = drvVal;  assign ifC.ex_rdy = drvExRdy[2];

  inst_router_rr #(.p_num_pipes(NP), .p_data_bits(DB), .p_rr_enable(1'b1)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(ifA));
  inst_router_rr #(.p_num_pipes(NP), .p_data_bits(DB), .p_rr_enable(1'b0)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(ifB));
  inst_router_rr #(.p_num_pipes(NP), .p_pipe_subsets(SUBS_C), .p_data_bits(DB), .p_rr_enable(1'b1)) dutC (
    .clk(clk), .rst_n(rst_n), .bus(ifC));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Gather the three DUTs' outputs into arrays indexed by DUT number.
  logic [NP-1:0]  obsVal   [ND];
  logic           obsRdy   [ND];
  logic           obsUnsup [ND];
  rv_uop          obsUop   [ND][NP];
  logic [DB-1:0]  obsData  [ND][NP];

  always_comb begin
    obsVal[0] = ifA.ex_val;  obsRdy[0] = ifA.rdy;  obsUnsup[0] = ifA.unsup;
    obsVal[1] = ifB.ex_val;  obsRdy[1] = ifB.rdy;  obsUnsup[1] = ifB.unsup;
    obsVal[2] = ifC.ex_val;  obsRdy[2] = ifC.rdy;  obsUnsup[2] = ifC.unsup;
    for (int p = 0; p < NP; p++) begin
      obsUop[0][p] = ifA.ex_uop[p];  obsData[0][p] = ifA.ex_data[p];
      obsUop[1][p] = ifB.ex_uop[p];  obsData[1][p] = ifB.ex_data[p];
      obsUop[2][p] = ifC.ex_uop[p];  obsData[2][p] = ifC.ex_data[p];
    end
  end

  // Reference model: what each pipe slot holds, plus pointer and drop flag per DUT.
  rv_op_vec       cfgSub [ND][NP];
  bit             cfgRr  [ND];
  logic [NP-1:0]  mVal   [ND];
  rv_uop          mUop   [ND][NP];
  logic [DB-1:0]  mData  [ND][NP];
  int             mPtr   [ND];
  logic           mUnsup [ND];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input rv_uop u, input logic [DB-1:0] dat, input logic v);
    drvUop  = u;
    drvData = dat;
    drvVal  = v;
  endtask

  task automatic resetModel();
    for (int d = 0; d < ND; d++) begin
      mVal[d]   = '0;
      mPtr[d]   = 0;
      mUnsup[d] = 1'b0;
    end
  endtask

  task automatic checkRoute(input int d, input int pipe, input logic [DB-1:0] expData, input string tag);
    checkOutput($sformatf("%s d%0d p%0d val", tag, d, pipe), 64'(obsVal[d][pipe]), 64'd1);
    checkOutput($sformatf("%s d%0d p%0d data", tag, d, pipe), 64'(obsData[d][pipe]), 64'(expData));
  endtask

  // Called in the low clock phase with inputs already driven: checks, clocks once, returns at negedge.
  task automatic stepCycle();
    logic [NP-1:0]  nVal   [ND];
    rv_uop          nUop   [ND][NP];
    logic [DB-1:0]  nData  [ND][NP];
    int             nPtr   [ND];
    logic           nUnsup [ND];
    #1;
    for (int d = 0; d < ND; d++) begin
      logic [NP-1:0] cap;
      logic [NP-1:0] el;
      logic          expRdy;
      logic          accept;
      int            win;
      int            start;
      int            idx;
      for (int p = 0; p < NP; p++) begin
        cap[p] = cfgSub[d][p][drvUop];
        el[p]  = cap[p] && (!mVal[d][p] || drvExRdy[d][p]);
      end
      expRdy = (|el) || !(|cap);
      checkOutput($sformatf("d%0d rdy", d), 64'(obsRdy[d]), 64'(expRdy));
      checkOutput($sformatf("d%0d ex_val", d), 64'(obsVal[d]), 64'(mVal[d]));
      checkOutput($sformatf("d%0d unsup", d), 64'(obsUnsup[d]), 64'(mUnsup[d]));
      for (int p = 0; p < NP; p++) begin
        if (mVal[d][p]) begin
          checkOutput($sformatf("d%0d p%0d uop", d, p), 64'(obsUop[d][p]), 64'(mUop[d][p]));
          checkOutput($sformatf("d%0d p%0d data", d, p), 64'(obsData[d][p]), 64'(mData[d][p]));
        end
      end
      win   = -1;
      start = cfgRr[d] ? mPtr[d] : 0;
      for (int k = 0; k < NP; k++) begin
        idx = (start + k) % NP;
        if (win < 0 && el[idx]) win = idx;
      end
      accept    = drvVal && expRdy && (|cap);
      nVal[d]   = mVal[d];
      nPtr[d]   = mPtr[d];
      nUnsup[d] = drvVal && !(|cap);
      for (int p = 0; p < NP; p++) begin
        nUop[d][p]  = mUop[d][p];
        nData[d][p] = mData[d][p];
        if (mVal[d][p] && drvExRdy[d][p]) nVal[d][p] = 1'b0;
      end
      if (accept) begin
        nVal[d][win]  = 1'b1;
        nUop[d][win]  = drvUop;
        nData[d][win] = drvData;
        nPtr[d]       = (win + 1) % NP;
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      resetModel();
    end else begin
      mVal   = nVal;
      mUop   = nUop;
      mData  = nData;
      mPtr   = nPtr;
      mUnsup = nUnsup;
    end
    @(negedge clk);
  endtask

  initial begin
    int expWrap [4] = '{0, 1, 0, 1};
    compareCount  = 0;
    mismatchCount = 0;
    for (int p = 0; p < NP; p++) begin
      cfgSub[0][p] = p_tinyrv1;
      cfgSub[1][p] = p_tinyrv1;
      cfgSub[2][p] = SUBS_C[p];
    end
    cfgRr = '{1'b1, 1'b0, 1'b1};
    for (int d = 0; d < ND; d++) drvExRdy[d] = 3'b111;

    // Reset held with a valid uop presented.
    rst_n = 1'b0;
    applyStimulus(OP_ADD, 32'h0, 1'b1);
    resetModel();
    repeat (2) stepCycle();
    for (int d = 0; d < ND; d++) begin
      checkOutput($sformatf("reset d%0d ex_val", d), 64'(obsVal[d]), 64'd0);
      checkOutput($sformatf("reset d%0d unsup", d), 64'(obsUnsup[d]), 64'd0);
    end
    rst_n = 1'b1;

    // Back-to-back ADDs: rotate on A, always pipe 0 on B.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(OP_ADD, 32'h100 + k, 1'b1);
      stepCycle();
      checkRoute(0, k % NP, 32'h100 + k, "rr");
      checkRoute(1, 0, 32'h100 + k, "fixed");
    end

    // Pipe 2 of A stalls full; search from the pointer wraps past it.
    drvExRdy[0] = 3'b011;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(OP_ADD, 32'h200 + k, 1'b1);
      stepCycle();
      checkRoute(0, expWrap[k], 32'h200 + k, "wrap");
    end
    checkOutput("wrap hold d0 p2", 64'(obsData[0][2]), 64'h105);

    // MUL-only pipe on C stalls, then drains and refills in one cycle.
    drvExRdy[0] = 3'b111;
    drvExRdy[2] = 3'b101;
    applyStimulus(OP_MUL, 32'h300, 1'b1);
    stepCycle();
    checkRoute(2, 1, 32'h300, "mul first");
    applyStimulus(OP_MUL, 32'h301, 1'b1);
    #1;
    checkOutput("mul blocked rdy", 64'(obsRdy[2]), 64'd0);
    stepCycle();
    checkRoute(2, 1, 32'h300, "mul held");
    stepCycle();
    checkRoute(2, 1, 32'h300, "mul held2");
    drvExRdy[2] = 3'b111;
    #1;
    checkOutput("mul drain rdy", 64'(obsRdy[2]), 64'd1);
    stepCycle();
    checkRoute(2, 1, 32'h301, "mul refill");

    // SW has no capable pipe on C: consumed, dropped, one-cycle flag.
    applyStimulus(OP_ADD, 32'h0, 1'b0);
    stepCycle();
    checkOutput("c drained ex_val", 64'(obsVal[2]), 64'd0);
    applyStimulus(OP_SW, 32'h400, 1'b1);
    #1;
    checkOutput("sw rdy", 64'(obsRdy[2]), 64'd1);
    stepCycle();
    checkOutput("sw no load", 64'(obsVal[2]), 64'd0);
    checkOutput("sw unsup", 64'(obsUnsup[2]), 64'd1);
    applyStimulus(OP_ADD, 32'h0, 1'b0);
    stepCycle();
    checkOutput("sw unsup pulse", 64'(obsUnsup[2]), 64'd0);

    // Randomized traffic and backpressure.
    repeat (400) begin
      applyStimulus(rv_uop'($urandom_range(0, 10)), $urandom, 1'($urandom_range(0, 3) != 0));
      for (int d = 0; d < ND; d++) drvExRdy[d] = 3'($urandom);
      stepCycle();
    end

    // Fill every pipe, then assert reset between clock edges.
    for (int d = 0; d < ND; d++) drvExRdy[d] = 3'b000;
    repeat (3) begin
      applyStimulus(OP_ADD, $urandom, 1'b1);
      stepCycle();
    end
    checkOutput("full d0 ex_val", 64'(obsVal[0]), 64'h7);
    checkOutput("full d1 ex_val", 64'(obsVal[1]), 64'h7);
    applyStimulus(OP_ADD, 32'h4ff, 1'b1);
    #1;
    checkOutput("full d0 rdy", 64'(obsRdy[0]), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      checkOutput($sformatf("async reset d%0d ex_val", d), 64'(obsVal[d]), 64'd0);
    end
    resetModel();
    stepCycle();
    rst_n = 1'b1;
    applyStimulus(OP_ADD, 32'h500, 1'b1);
    stepCycle();
    checkRoute(0, 0, 32'h500, "post reset");
    applyStimulus(OP_ADD, 32'h0, 1'b0);
    stepCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
